gate_stim_seq: RTL
==================

# gate_stim_seq

Exhaustive stimulus sequencer that sits directly upstream of the basic two-input logic gates, such as the XNOR cell. It drives every input combination onto the gate in ascending binary order and holds each vector for a programmable number of clock cycles. A start/stop/done handshake lets a bench or a higher-level controller run repeated sweeps. An optional response checker compares the gate output against the expected XNOR value and counts mismatches.

## Interface
- `N_IN`, default 2: vector width; sweep covers 0 to 2^N_IN−1. Legal range 1..8.
- `HOLD`, default 5: cycles each vector is held. Must be ≥1.
- `clk` in, 1: the only clock; all state updates on the rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `start` in, 1: request a sweep; sampled only in IDLE.
- `stop` in, 1: abort a sweep; sampled in DRIVE and IDLE.
- `vec` out, N_IN: stimulus vector; bit N_IN−1 maps to gate input `a`, bit 0 to `b`.
- `vec_valid` out, 1: high while `vec` is being driven (DRIVE state).
- `busy` out, 1: high in DRIVE.
- `done` out, 1: one-cycle pulse when a sweep completes normally.
- `dut_y` in, 1: gate output. Present only with `GATE_CHECK_EN`.
- `err_cnt` out, 8: mismatch count. Present only with `GATE_CHECK_EN`.
- `pass` out, 1: sweep result. Present only with `GATE_CHECK_EN`.

## Operation
- FSM states are IDLE, DRIVE and DONE. Registered outputs: `vec`, `vec_valid`, `busy`, `done`, `err_cnt`, `pass`.
- Reset forces IDLE, hold counter 0, and every output 0.
- **IDLE:** `vec`=0, `vec_valid`=0, `busy`=0.
  - `start`=1 with `stop`=0: go to DRIVE; `vec`=0; hold counter=0.
  - `start`=1 with `stop`=1: remain in IDLE (`stop` wins).
- **DRIVE:** `vec_valid`=1, `busy`=1; the hold counter increments every cycle.
  - When hold counter = HOLD−1 and `vec` < 2^N_IN−1: `vec` increments and the hold counter returns to 0.
  - When hold counter = HOLD−1 and `vec` = 2^N_IN−1: go to DONE.
  - `stop`=1 has priority: go to IDLE on the next edge, with no `done` pulse. `vec` and the counter clear to 0.
  - `start` is ignored while in DRIVE.
- **DONE:** `done`=1 for exactly one cycle; `vec_valid`=0, `busy`=0, `vec`=0. Next state is IDLE unconditionally.
  - `start` asserted during DONE is ignored. It must be held into IDLE to be accepted.
- `vec` never wraps. The last vector is terminal.
- Asynchronous reset mid-sweep returns to IDLE immediately. No `done` is produced.

## Timing
- `start` sampled at edge E0: `vec`=0, `vec_valid`=1 and `busy`=1 are visible after E0.
- Vector k is driven in the cycles following edges E0+k·HOLD through E0+(k+1)·HOLD−1.
- DRIVE lasts HOLD·2^N_IN cycles. `done` is high in the cycle following edge E0+HOLD·2^N_IN.
- For HOLD=1 each vector lasts a single cycle.
- The earliest next sweep is accepted one cycle after `done` (back in IDLE).
- `stop` sampled at edge Es: all outputs are back to IDLE values after edge Es+1.

## Configuration
- Macro `GATE_CHECK_EN`.
- **Defined:** `dut_y`, `err_cnt` and `pass` exist and the checker is active.
  - Expected value is `~^vec` (reduction XNOR).
  - `dut_y` is compared on the last hold cycle of each vector, when hold counter = HOLD−1.
  - Each mismatch increments `err_cnt`, saturating at 255.
  - `err_cnt` and `pass` clear to 0 when `start` is accepted.
  - `pass` is set to (`err_cnt` final == 0) in DONE and held until the next accepted `start`.
  - After `stop` or reset, `pass` stays 0.
- **Undefined:** the ports and checker logic are absent. Sequencing behaviour is identical.

## Test plan
- Reset then idle (N_IN=2, HOLD=5): `rst_n` low then high, no `start` → `vec`=0, `vec_valid`=0, `busy`=0, `done`=0.
- Full sweep (N_IN=2, HOLD=5): pulse `start` → `vec` = 0,1,2,3, each for 5 cycles (20 cycles total); `done` pulses once, 21 cycles after the `start` edge; `busy` falls with it.
- Abort (N_IN=2, HOLD=5): `stop` during vector 2, cycle 3 → next cycle IDLE, `vec`=0, no `done`. A fresh `start` restarts from vector 0.
- Edge cases (N_IN=2, HOLD=1): `start` and `stop` asserted together in IDLE → no sweep. `start` alone → `vec` 0,1,2,3 on consecutive cycles; `done` 5 cycles after the `start` edge; `start` held throughout → second sweep starts only after `done`.
- Checker, correct gate (`GATE_CHECK_EN`, N_IN=2, HOLD=5): `dut_y` from a correct XNOR gate → `err_cnt`=0 and `pass`=1 after `done`.
- Checker, faulty gate (`GATE_CHECK_EN`, N_IN=2, HOLD=5): `dut_y` from an XOR gate instead → `err_cnt`=4, `pass`=0. Asserting `rst_n` low mid-sweep clears all outputs to 0 immediately.

Source files
------------

// File: rtl/gate_stim_seq_if.sv
// Sequencer <-> bench/controller bundle: start/stop request, stimulus vector and status.
// Latency: none, wires only.
// Backpressure: none; the consumer must accept vec every cycle vec_valid is high.
interface gate_stim_seq_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            stop;
  logic [N_IN-1:0] vec;
  logic            vec_valid;
  logic            busy;
  logic            done;
`ifdef GATE_CHECK_EN
  logic            dut_y;
  logic [7:0]      err_cnt;
  logic            pass;

  modport master (
    input  start, stop, dut_y,
    output vec, vec_valid, busy, done, err_cnt, pass
  );
  modport slave (
    output start, stop, dut_y,
    input  vec, vec_valid, busy, done, err_cnt, pass
  );
`else
  modport master (
    input  start, stop,
    output vec, vec_valid, busy, done
  );
  modport slave (
    output start, stop,
    input  vec, vec_valid, busy, done
  );
`endif
endinterface

// File: rtl/gate_stim_seq.sv
// Exhaustive ascending-order stimulus sweep for a small gate, each vector held HOLD cycles.
// Latency: registered outputs, one edge after start; done one edge after the last hold cycle.
// Backpressure: none; stop aborts a sweep. GATE_CHECK_EN adds the XNOR response checker.
module gate_stim_seq #(
  parameter int N_IN = 2,
  parameter int HOLD = 5
) (
  input logic           clk,
  input logic           rst_n,
  gate_stim_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N_IN-1:0] vec, vec_n;
  logic            vec_valid, vec_valid_n;
  logic            busy, busy_n;
  logic            done, done_n;
`ifdef GATE_CHECK_EN
  logic [7:0]      err_cnt, err_cnt_n;
  logic            pass, pass_n;
`endif

  // Next state and next registered outputs; all outputs default to their idle values.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    vec_n       = vec;
    vec_valid_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
`ifdef GATE_CHECK_EN
    err_cnt_n   = err_cnt;
    pass_n      = pass;
`endif
    case (state)
      IDLE: begin
        // stop overrides a simultaneous start
        if (bus.start && !bus.stop) begin
          state_n     = DRIVE;
          cnt_n       = '0;
          vec_n       = '0;
          vec_valid_n = 1'b1;
          busy_n      = 1'b1;
`ifdef GATE_CHECK_EN
          err_cnt_n   = 8'd0;
          pass_n      = 1'b0;
`endif
        end
      end
      DRIVE: begin
        if (bus.stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          vec_n   = '0;
        end else begin
          vec_valid_n = 1'b1;
          busy_n      = 1'b1;
          if (cnt == CNT_LAST) begin
`ifdef GATE_CHECK_EN
            // Sample the gate on the last hold cycle so it has settled.
            if ((bus.dut_y != (~^vec)) && (err_cnt != 8'hFF))
              err_cnt_n = err_cnt + 8'd1;
`endif
            cnt_n = '0;
            if (vec == VEC_LAST) begin
              // Terminal vector: no wrap, the sweep finishes here.
              state_n     = DONE;
              vec_n       = '0;
              vec_valid_n = 1'b0;
              busy_n      = 1'b0;
              done_n      = 1'b1;
`ifdef GATE_CHECK_EN
              pass_n      = (err_cnt_n == 8'd0);
`endif
            end else begin
              vec_n = vec + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        // start here is ignored; it has to be held into IDLE
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        vec_n   = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      vec       <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef GATE_CHECK_EN
      err_cnt   <= 8'd0;
      pass      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      vec       <= vec_n;
      vec_valid <= vec_valid_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef GATE_CHECK_EN
      err_cnt   <= err_cnt_n;
      pass      <= pass_n;
`endif
    end
  end

  assign bus.vec       = vec;
  assign bus.vec_valid = vec_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
`ifdef GATE_CHECK_EN
  assign bus.err_cnt   = err_cnt;
  assign bus.pass      = pass;
`endif

endmodule
